trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 150 +++++++++++++++
 tb/tb_trap_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: accepts exceptions, MRET and timer/software interrupts at
// commit, writes the trap CSRs, reads the vector or return address and redirects fetch.
module trap_ctrl #(
    parameter bit IRQ_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid_i,
    input  logic [63:0] commit_pc_i,
    input  logic        exc_i,
    input  logic [4:0]  exc_code_i,
    input  logic [63:0] exc_tval_i,
    input  logic        mret_i,
    input  logic        irq_timer_i,
    input  logic        irq_soft_i,
    input  logic        mstatus_ie_i,
    input  logic        mie_mtie_i,
    input  logic        mie_msie_i,
    input  logic [63:0] csr_rdata_i,
    output logic        csr_rsel_o,
    output logic [11:0] csr_raddr_o,
    output logic        csr_we_o,
    output logic [11:0] csr_waddr_o,
    output logic [63:0] csr_wdata_o,
    output logic        we_mepc_o,
    output logic [63:0] wdata_mepc_o,
    output logic        we_mcause_o,
    output logic [63:0] wdata_mcause_o,
    output logic        we_mtval_o,
    output logic [63:0] wdata_mtval_o,
    output logic        exception_mie_req_o,
    output logic        stall_o,
    output logic        flush_o,
    output logic [63:0] redirect_pc_o,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TRAP_WR = 3'd1,
        VEC_RD  = 3'd2,
        MRET_RD = 3'd3,
        MRET_WR = 3'd4,
        REDIR   = 3'd5
    } state_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;

    state_t      state, state_next;
    logic [63:0] pc_q, cause_q, tval_q, target_q;
    logic        timer_ok, soft_ok, accept;

    // Handshake: commit_valid_i is the valid and ~stall_o the ready; the committing
    // instruction retires only in a cycle with commit_valid_i=1 and stall_o=0.
    assign timer_ok  = IRQ_EN && irq_timer_i && mie_mtie_i && mstatus_ie_i;
    assign soft_ok   = IRQ_EN && irq_soft_i && mie_msie_i && mstatus_ie_i;
    assign accept    = !rst && (state == IDLE) && commit_valid_i &&
                       (exc_i || mret_i || timer_ok || soft_ok);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc_q     <= '0;
            cause_q  <= '0;
            tval_q   <= '0;
            target_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                pc_q <= commit_pc_i;
                if (exc_i) begin
                    cause_q <= {1'b0, 58'h0, exc_code_i};
                    tval_q  <= exc_tval_i;
                end else if (!mret_i) begin
                    cause_q <= timer_ok ? {1'b1, 58'h0, 5'd7} : {1'b1, 58'h0, 5'd3};
                    tval_q  <= '0;
                end
            end
            if (state == VEC_RD || state == MRET_RD) begin
                target_q <= csr_rdata_i;
            end
        end
    end

    always_comb begin
        state_next          = state;
        csr_rsel_o          = 1'b0;
        csr_raddr_o         = '0;
        csr_we_o            = 1'b0;
        csr_waddr_o         = '0;
        csr_wdata_o         = '0;
        we_mepc_o           = 1'b0;
        wdata_mepc_o        = '0;
        we_mcause_o         = 1'b0;
        wdata_mcause_o      = '0;
        we_mtval_o          = 1'b0;
        wdata_mtval_o       = '0;
        exception_mie_req_o = 1'b0;
        flush_o             = 1'b0;
        redirect_pc_o       = '0;
        stall_o             = accept || (state != IDLE);
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (!exc_i && mret_i) ? MRET_RD : TRAP_WR;
                end
            end
            TRAP_WR: begin
                we_mepc_o           = 1'b1;
                wdata_mepc_o        = pc_q;
                we_mcause_o         = 1'b1;
                wdata_mcause_o      = cause_q;
                we_mtval_o          = 1'b1;
                wdata_mtval_o       = tval_q;
                exception_mie_req_o = 1'b1;
                state_next          = VEC_RD;
            end
            VEC_RD: begin
                csr_rsel_o  = 1'b1;
                csr_raddr_o = CSR_MTVEC;
                state_next  = REDIR;
            end
            MRET_RD: begin
                csr_rsel_o  = 1'b1;
                csr_raddr_o = CSR_MEPC;
                state_next  = MRET_WR;
            end
            MRET_WR: begin
                // Restore IE from IE1 (read back this same cycle) and set IE1.
                csr_rsel_o     = 1'b1;
                csr_raddr_o    = CSR_MSTATUS;
                csr_we_o       = 1'b1;
                csr_waddr_o    = CSR_MSTATUS;
                csr_wdata_o[7] = 1'b1;
                csr_wdata_o[3] = csr_rdata_i[7];
                state_next     = REDIR;
            end
            REDIR: begin
                flush_o       = 1'b1;
                redirect_pc_o = target_q;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: stimulus pushes timestamped expected CSR writes and flushes
// into a queue, a negedge monitor pops and compares them as the DUT produces them.
module tb_trap_ctrl;

    localparam int W = 210;  // {kind[1:0], cycle[15:0], d0[63:0], d1[63:0], d2[63:0]}

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid, exc, mret, irq_timer, irq_soft;
    logic        mstatus_ie, mie_mtie, mie_msie;
    logic [63:0] commit_pc, exc_tval, csr_rdata;
    logic [4:0]  exc_code;
    logic [63:0] mtvec_val, mepc_val, mstatus_val;

    logic        csr_rsel, csr_we, we_mepc, we_mcause, we_mtval, mie_req, stall, flush;
    logic [11:0] csr_raddr, csr_waddr;
    logic [63:0] csr_wdata, wdata_mepc, wdata_mcause, wdata_mtval, redirect_pc;
    logic [2:0]  dbg_state;

    logic        n_csr_rsel, n_csr_we, n_we_mepc, n_we_mcause, n_we_mtval, n_mie_req;
    logic        n_stall, n_flush;
    logic [11:0] n_csr_raddr, n_csr_waddr;
    logic [63:0] n_csr_wdata, n_wdata_mepc, n_wdata_mcause, n_wdata_mtval, n_redirect_pc;
    logic [2:0]  n_dbg_state;

    logic [W-1:0] exp_q[$];
    logic [15:0]  cyc = '0;
    int           checks = 0;
    int           failures = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 16'd1;

    // CSR file model answering the DUT's combinational read port
    always_comb begin
        case (csr_raddr)
            12'h305: csr_rdata = mtvec_val;
            12'h341: csr_rdata = mepc_val;
            12'h300: csr_rdata = mstatus_val;
            default: csr_rdata = 64'h0;
        endcase
    end

    trap_ctrl #(.IRQ_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .commit_valid_i(commit_valid), .commit_pc_i(commit_pc),
        .exc_i(exc), .exc_code_i(exc_code), .exc_tval_i(exc_tval), .mret_i(mret),
        .irq_timer_i(irq_timer), .irq_soft_i(irq_soft), .mstatus_ie_i(mstatus_ie),
        .mie_mtie_i(mie_mtie), .mie_msie_i(mie_msie), .csr_rdata_i(csr_rdata),
        .csr_rsel_o(csr_rsel), .csr_raddr_o(csr_raddr), .csr_we_o(csr_we),
        .csr_waddr_o(csr_waddr), .csr_wdata_o(csr_wdata), .we_mepc_o(we_mepc),
        .wdata_mepc_o(wdata_mepc), .we_mcause_o(we_mcause), .wdata_mcause_o(wdata_mcause),
        .we_mtval_o(we_mtval), .wdata_mtval_o(wdata_mtval), .exception_mie_req_o(mie_req),
        .stall_o(stall), .flush_o(flush), .redirect_pc_o(redirect_pc), .dbg_state(dbg_state)
    );

    trap_ctrl #(.IRQ_EN(1'b0)) dut_noirq (
        .clk(clk), .rst(rst), .commit_valid_i(commit_valid), .commit_pc_i(commit_pc),
        .exc_i(exc), .exc_code_i(exc_code), .exc_tval_i(exc_tval), .mret_i(mret),
        .irq_timer_i(irq_timer), .irq_soft_i(irq_soft), .mstatus_ie_i(mstatus_ie),
        .mie_mtie_i(mie_mtie), .mie_msie_i(mie_msie), .csr_rdata_i(csr_rdata),
        .csr_rsel_o(n_csr_rsel), .csr_raddr_o(n_csr_raddr), .csr_we_o(n_csr_we),
        .csr_waddr_o(n_csr_waddr), .csr_wdata_o(n_csr_wdata), .we_mepc_o(n_we_mepc),
        .wdata_mepc_o(n_wdata_mepc), .we_mcause_o(n_we_mcause), .wdata_mcause_o(n_wdata_mcause),
        .we_mtval_o(n_we_mtval), .wdata_mtval_o(n_wdata_mtval), .exception_mie_req_o(n_mie_req),
        .stall_o(n_stall), .flush_o(n_flush), .redirect_pc_o(n_redirect_pc),
        .dbg_state(n_dbg_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic sb_compare(input string name, input logic [W-1:0] obs);
        logic [W-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_%s unexpected: got %h expected nothing", name, obs);
        end else begin
            e = exp_q.pop_front();
            if (e !== obs) begin
                failures++;
                $display("FAIL sb_%s: got %h expected %h", name, obs, e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (we_mepc || we_mcause || we_mtval || mie_req)
                sb_compare("trap_wr", {(we_mepc && we_mcause && we_mtval && mie_req) ? 2'd1 : 2'd0,
                                       cyc, wdata_mepc, wdata_mcause, wdata_mtval});
            if (csr_we)
                sb_compare("csr_wr", {2'd2, cyc, 52'h0, csr_waddr, csr_wdata, 64'h0});
            if (flush)
                sb_compare("flush", {2'd3, cyc, redirect_pc, 128'h0});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        commit_valid = 1'b0; exc = 1'b0; mret = 1'b0; irq_timer = 1'b0; irq_soft = 1'b0;
        commit_pc = '0; exc_code = '0; exc_tval = '0;
    endtask

    // kind: 0 = no event expected, 1 = trap sequence, 2 = MRET sequence
    task automatic issue(input logic [63:0] pc, input logic e, input logic [4:0] code,
                         input logic [63:0] tval, input logic m, input logic t, input logic s,
                         input int kind, input logic [63:0] e_cause, input logic [63:0] e_tval,
                         input logic [63:0] e_target, input logic [63:0] e_mst,
                         input logic e_stall_noirq);
        logic [15:0] n;
        @(posedge clk); #1;
        commit_valid = 1'b1; commit_pc = pc; exc = e; exc_code = code; exc_tval = tval;
        mret = m; irq_timer = t; irq_soft = s;
        n = cyc;
        if (kind == 1) begin
            exp_q.push_back({2'd1, n + 16'd1, pc, e_cause, e_tval});
            exp_q.push_back({2'd3, n + 16'd3, e_target, 128'h0});
        end else if (kind == 2) begin
            exp_q.push_back({2'd2, n + 16'd2, 52'h0, 12'h300, e_mst, 64'h0});
            exp_q.push_back({2'd3, n + 16'd3, e_target, 128'h0});
        end
        @(negedge clk);
        check("stall_accept", {63'h0, stall}, {63'h0, kind != 0});
        check("stall_noirq_inst", {63'h0, n_stall}, {63'h0, e_stall_noirq});
        @(posedge clk); #1;
        clear_inputs();
        if (kind != 0) begin
            for (int k = 1; k <= 3; k++) begin
                @(negedge clk);
                check("stall_busy", {63'h0, stall}, 64'h1);
            end
        end else begin
            @(negedge clk);
            check("stall_none", {63'h0, stall}, 64'h0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] n;
        rst = 1'b1;
        clear_inputs();
        mstatus_ie = 1'b1; mie_mtie = 1'b1; mie_msie = 1'b1;
        mtvec_val = 64'h8000_0100; mepc_val = 64'h0; mstatus_val = 64'h0;
        commit_valid = 1'b1; exc = 1'b1;
        @(negedge clk);
        check("rst_stall", {63'h0, stall}, 64'h0);
        check("rst_flush", {63'h0, flush}, 64'h0);
        check("rst_we_mepc", {63'h0, we_mepc}, 64'h0);
        check("rst_csr_rsel", {63'h0, csr_rsel}, 64'h0);
        check("rst_redirect", redirect_pc, 64'h0);
        check("rst_state", {61'h0, dbg_state}, 64'h0);
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;

        // exception: mepc 0x8000_0010, mcause 2, mtval 0xDEAD, vector 0x8000_0100
        issue(64'h8000_0010, 1, 5'd2, 64'hDEAD, 0, 0, 0, 1,
              64'h2, 64'hDEAD, 64'h8000_0100, 64'h0, 1);
        // timer irq (irq drops right after acceptance)
        issue(64'h8000_0020, 0, 5'd0, 64'h0, 0, 1, 0, 1,
              64'h8000_0000_0000_0007, 64'h0, 64'h8000_0100, 64'h0, 0);
        mtvec_val = 64'h8000_0200;
        issue(64'h8000_0030, 0, 5'd0, 64'h0, 0, 0, 1, 1,
              64'h8000_0000_0000_0003, 64'h0, 64'h8000_0200, 64'h0, 0);
        // MRET with IE1=1, then back-to-back MRET with IE1=0
        mepc_val = 64'h8000_0024; mstatus_val = 64'h80;
        issue(64'h8000_0040, 0, 5'd0, 64'h0, 1, 0, 0, 2,
              64'h0, 64'h0, 64'h8000_0024, 64'h88, 1);
        mepc_val = 64'h8000_1000; mstatus_val = 64'h08;
        issue(64'h8000_0044, 0, 5'd0, 64'h0, 1, 0, 0, 2,
              64'h0, 64'h0, 64'h8000_1000, 64'h80, 1);
        // exception beats MRET and timer
        issue(64'h8000_0050, 1, 5'd5, 64'h1234, 1, 1, 0, 1,
              64'h5, 64'h1234, 64'h8000_0200, 64'h0, 1);
        // timer beats soft
        issue(64'h8000_0060, 0, 5'd0, 64'h0, 0, 1, 1, 1,
              64'h8000_0000_0000_0007, 64'h0, 64'h8000_0200, 64'h0, 0);
        // MRET beats timer
        mepc_val = 64'h8000_0070; mstatus_val = 64'h80;
        issue(64'h8000_0068, 0, 5'd0, 64'h0, 1, 1, 0, 2,
              64'h0, 64'h0, 64'h8000_0070, 64'h88, 1);
        // masked interrupts are ignored
        mstatus_ie = 1'b0;
        issue(64'h8000_0080, 0, 5'd0, 64'h0, 0, 1, 1, 0, 64'h0, 64'h0, 64'h0, 64'h0, 0);
        mstatus_ie = 1'b1; mie_mtie = 1'b0;
        issue(64'h8000_0084, 0, 5'd0, 64'h0, 0, 1, 0, 0, 64'h0, 64'h0, 64'h0, 64'h0, 0);
        mie_mtie = 1'b1;

        // exception without commit_valid is not accepted
        @(posedge clk); #1;
        exc = 1'b1; exc_code = 5'd4;
        @(negedge clk);
        check("no_valid_stall", {63'h0, stall}, 64'h0);
        clear_inputs();

        // reset during VEC_RD: trap CSR write happens, flush must not
        @(posedge clk); #1;
        commit_valid = 1'b1; commit_pc = 64'h8000_0090; exc = 1'b1; exc_code = 5'd6;
        exc_tval = 64'h77;
        n = cyc;
        exp_q.push_back({2'd1, n + 16'd1, 64'h8000_0090, 64'h6, 64'h77});
        @(posedge clk); #1;
        clear_inputs();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_state", {61'h0, dbg_state}, 64'h0);
        check("mid_rst_stall", {63'h0, stall}, 64'h0);
        check("mid_rst_rsel", {63'h0, csr_rsel}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_flush", {63'h0, flush}, 64'h0);
        end
        issue(64'h8000_00A0, 1, 5'd2, 64'hBEEF, 0, 0, 0, 1,
              64'h2, 64'hBEEF, 64'h8000_0200, 64'h0, 1);

        repeat (4) @(negedge clk);
        check("sb_queue_drained", 64'(exp_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
